// File: rtl/definitions_pkg.sv
// definitions_pkg
// Shared types and constants for the weight datapath.
//   s_weight_t : one signed weight as carried on the weight memory / PE buses
//   seq_t      : request tag attached to each weight-memory beat
//   BM_SIZE    : weights per group in block-mode
//   DEF_*      : default lane counts for the repacker
package definitions_pkg;

  localparam int WEIGHT_W      = 8;
  localparam int SEQ_W         = 4;
  localparam int BM_SIZE       = 4;

  localparam int DEF_IN_LANES  = 8;
  localparam int DEF_OUT_LANES = 8;
  localparam int DEF_BUF_LANES = 16;

  typedef logic signed [WEIGHT_W-1:0] s_weight_t;
  typedef logic [SEQ_W-1:0]           seq_t;

endpackage

// File: rtl/weight_repack_shift.sv
// weight_repack_shift
// Purely combinational next-buffer generator for the repacker's residual
// lane buffer. Drops `shift` weights off the bottom of the buffer, then
// places the insert beat directly above whatever remains.
// Ports:
//   buf_q  : current buffer, lane 0 oldest; lanes >= level must be zero
//   level  : weights currently held in buf_q
//   shift  : weights removed this cycle (must be <= level)
//   beat   : IN_LANES weights to append
//   ins_en : append the beat
//   buf_d  : resulting buffer; lanes above the new level are zero
module weight_repack_shift
  import definitions_pkg::*;
#(
  parameter int IN_LANES  = DEF_IN_LANES,
  parameter int BUF_LANES = DEF_BUF_LANES
) (
  input  s_weight_t [BUF_LANES-1:0]         buf_q,
  input  logic [$clog2(BUF_LANES+1)-1:0]    level,
  input  logic [$clog2(BUF_LANES+1)-1:0]    shift,
  input  s_weight_t [IN_LANES-1:0]          beat,
  input  logic                              ins_en,
  output s_weight_t [BUF_LANES-1:0]         buf_d
);

  localparam int LVL_W = $clog2(BUF_LANES+1);
  localparam int BUF_W = BUF_LANES * WEIGHT_W;

  logic [LVL_W-1:0] base;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;

  // Lanes at and above `level` are zero, so a whole-vector shift leaves
  // zeros above level-shift and the beat can simply be OR-ed in there.
  assign base    = level - shift;
  assign shifted = buf_q >> (shift * WEIGHT_W);
  assign placed  = ins_en ? (BUF_W'(beat) << (base * WEIGHT_W)) : '0;
  assign buf_d   = shifted | placed;

endmodule

// File: rtl/weight_repacker.sv
// weight_repacker
// Repacks fixed-width weight-memory beats into a variable number of weights
// per output cycle for the PE weight bus, with full back-pressure.
// Optional build macro: WEIGHT_REPACK_SEQ_CHECK_EN -- when defined, beats whose
// tag differs from exp_seq are consumed but not buffered and counted in
// drop_cnt; when undefined, tags are ignored and drop_cnt reads 0.
// Ports:
//   clock, resetN     : clock; synchronous active-low reset
//   in_valid/in_ready : input beat handshake; in_data lane 0 is oldest
//   in_seq, exp_seq   : beat tag and expected tag
//   mode, req_len     : 0 = req_len weights, 1 = req_len*BM_SIZE weights
//   freeze            : blocks output (input still accepted)
//   flush             : empties the buffer and clears len_err
//   out_valid/out_take: output handshake; out_data shows the first `need` lanes
//   level             : weights currently buffered
//   len_err           : sticky, set by a take request longer than OUT_LANES
//   drop_cnt          : saturating count of mismatched-tag beats
// BUF_LANES must be at least IN_LANES + OUT_LANES - 1.
module weight_repacker
  import definitions_pkg::*;
#(
  parameter int IN_LANES  = DEF_IN_LANES,
  parameter int OUT_LANES = DEF_OUT_LANES,
  parameter int BUF_LANES = DEF_BUF_LANES,
  parameter int LEN_W     = $clog2(OUT_LANES+1)
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  s_weight_t [IN_LANES-1:0]          in_data,
  input  seq_t                              in_seq,
  input  seq_t                              exp_seq,
  input  logic                              mode,
  input  logic [LEN_W-1:0]                  req_len,
  input  logic                              freeze,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_take,
  output s_weight_t [OUT_LANES-1:0]         out_data,
  output logic [$clog2(BUF_LANES+1)-1:0]    level,
  output logic                              len_err,
  output logic [7:0]                        drop_cnt
);

  localparam int LVL_W  = $clog2(BUF_LANES+1);
  localparam int NEED_W = LEN_W + $clog2(BM_SIZE) + 1;
  // One bit wider than either operand so free-space sums never wrap.
  localparam int CMP_W  = ((NEED_W > LVL_W) ? NEED_W : LVL_W) + 1;

  s_weight_t [BUF_LANES-1:0] buf_q;
  s_weight_t [BUF_LANES-1:0] buf_d;
  logic [NEED_W-1:0]         need;
  logic [CMP_W-1:0]          need_x;
  logic [CMP_W-1:0]          level_x;
  logic [CMP_W-1:0]          take_amt;
  logic [CMP_W-1:0]          wr_amt;
  logic [CMP_W-1:0]          free_x;
  logic [LVL_W-1:0]          shift;
  logic                      take;
  logic                      acc;
  logic                      wr;
  logic                      len_bad;

  assign need    = mode ? (NEED_W'(req_len) * NEED_W'(BM_SIZE)) : NEED_W'(req_len);
  assign need_x  = CMP_W'(need);
  assign level_x = CMP_W'(level);
  assign len_bad = need_x > CMP_W'(OUT_LANES);

  assign out_valid = resetN && (level_x >= need_x) && (need != '0) && !freeze && !len_err;
  assign take      = out_take && out_valid;
  assign take_amt  = take ? need_x : '0;

  // Space freed by a same-cycle take counts toward accepting a beat.
  assign free_x   = CMP_W'(BUF_LANES) - level_x + take_amt;
  assign in_ready = resetN && !flush && (free_x >= CMP_W'(IN_LANES));
  assign acc      = in_valid && in_ready;
  assign wr_amt   = wr ? CMP_W'(IN_LANES) : '0;

`ifdef WEIGHT_REPACK_SEQ_CHECK_EN
  logic [7:0] drop_q;

  assign wr       = acc && (in_seq == exp_seq);
  assign drop_cnt = drop_q;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      drop_q <= '0;
    end else if (acc && (in_seq != exp_seq) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end
`else
  logic unused_seq;

  assign unused_seq = ^{in_seq, exp_seq};
  assign wr         = acc;
  assign drop_cnt   = '0;
`endif

  // A take never exceeds level, so need fits in the level width here.
  assign shift = take ? LVL_W'(need) : '0;

  weight_repack_shift #(
    .IN_LANES  (IN_LANES),
    .BUF_LANES (BUF_LANES)
  ) u_shift (
    .buf_q  (buf_q),
    .level  (level),
    .shift  (shift),
    .beat   (in_data),
    .ins_en (wr),
    .buf_d  (buf_d)
  );

  always_ff @(posedge clock) begin
    if (!resetN || flush) begin
      level   <= '0;
      buf_q   <= '0;
      len_err <= 1'b0;
    end else begin
      buf_q <= buf_d;
      level <= LVL_W'(level_x - take_amt + wr_amt);
      if (out_take && len_bad) begin
        len_err <= 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      if (i < int'(need)) begin
        out_data[i] = buf_q[i];
      end
    end
  end

endmodule
